// File: rtl/ultrasonic_echo_capture.sv
// ultrasonic_echo_capture
//   Multi-channel ultrasonic ranging front end. Fires a trigger pulse on
//   each sensor in turn, measures the returned echo pulse width in clk
//   cycles through a synchronised input, and publishes one tagged result
//   per measurement.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   start    in   single-shot request, sampled only in IDLE
//   auto_en  in   free-running round-robin mode while high
//   echo     in   [CHANNELS] raw asynchronous echo inputs
//   trig     out  [CHANNELS] trigger outputs, at most one bit high
//   width    out  [WIDTH] last measured pulse width, held until next result
//   chan     out  [CW] channel index of the last result
//   valid    out  one-cycle strobe when width/chan/timeout update
//   timeout  out  current result had no echo or a saturated count
//   busy     out  high in every state except IDLE

module ultrasonic_echo_capture #(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned TRIG_CYCLES   = 120,
    parameter int unsigned RISE_TIMEOUT  = 6000,
    parameter int unsigned PERIOD_CYCLES = 720000,
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                auto_en,
    input  logic [CHANNELS-1:0] echo,
    output logic [CHANNELS-1:0] trig,
    output logic [WIDTH-1:0]    width,
    output logic [CW-1:0]       chan,
    output logic                valid,
    output logic                timeout,
    output logic                busy
);

    localparam logic [31:0]         TRIG_LAST   = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0]         RISE_LAST   = 32'(RISE_TIMEOUT - 1);
    localparam logic [31:0]         PERIOD_LAST = 32'(PERIOD_CYCLES - 1);
    localparam logic [WIDTH-1:0]    CNT_MAX     = '1;
    localparam logic [WIDTH-1:0]    CNT_NEAR    = CNT_MAX - 1'b1;
    localparam logic [CW-1:0]       PTR_LAST    = CW'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0] TRIG_ONE    = CHANNELS'(1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t              state;
    logic [CW-1:0]       ptr;
    logic [CW-1:0]       ptr_next;
    logic [31:0]         tcnt;
    logic [31:0]         period;
    logic [WIDTH-1:0]    cnt;

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] es;
    logic [CHANNELS-1:0] es_d;
    logic                sel_es;
    logic                sel_rise;

    // Echo synchronisers plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            es_d <= '0;
        end else begin
            sync_q[0] <= echo;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            es_d <= es;
        end
    end

    always_comb begin
        es       = sync_q[SYNC_STAGES-1];
        sel_es   = es[ptr];
        // An echo already high when WAIT_RISE starts has es_d set, so it
        // never looks like a rise and a stuck-high sensor times out.
        sel_rise = es[ptr] & ~es_d[ptr];
        ptr_next = (ptr == PTR_LAST) ? '0 : ptr + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            tcnt    <= '0;
            period  <= '0;
            cnt     <= '0;
            trig    <= '0;
            width   <= '0;
            chan    <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b0;
        end else begin
            valid <= 1'b0;

            // Period counter saturates at its terminal value so HOLDOFF can
            // exit at once if the measurement already used the full period.
            if (state != IDLE && period < PERIOD_LAST) begin
                period <= period + 32'd1;
            end

            unique case (state)
                IDLE: begin
                    if (start || auto_en) begin
                        state  <= TRIG;
                        trig   <= TRIG_ONE << ptr;
                        tcnt   <= '0;
                        period <= '0;
                        busy   <= 1'b1;
                    end
                end

                TRIG: begin
                    if (tcnt == TRIG_LAST) begin
                        trig  <= '0;
                        tcnt  <= '0;
                        state <= WAIT_RISE;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end

                WAIT_RISE: begin
                    if (sel_rise) begin
                        cnt   <= WIDTH'(1);
                        state <= MEASURE;
                    end else if (tcnt == RISE_LAST) begin
                        width   <= '0;
                        timeout <= 1'b1;
                        chan    <= ptr;
                        valid   <= 1'b1;
                        state   <= HOLDOFF;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end

                MEASURE: begin
                    if (!sel_es) begin
                        width   <= cnt;
                        timeout <= 1'b0;
                        chan    <= ptr;
                        valid   <= 1'b1;
                        state   <= HOLDOFF;
                    end else if (cnt == CNT_NEAR) begin
                        // This high sample would take the count to all-ones:
                        // report saturation without waiting for the fall.
                        width   <= CNT_MAX;
                        timeout <= 1'b1;
                        chan    <= ptr;
                        valid   <= 1'b1;
                        state   <= HOLDOFF;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end

                HOLDOFF: begin
                    if (period >= PERIOD_LAST) begin
                        ptr <= ptr_next;
                        if (auto_en) begin
                            state  <= TRIG;
                            trig   <= TRIG_ONE << ptr_next;
                            tcnt   <= '0;
                            period <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    trig  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_capture.sv
// tb_ultrasonic_echo_capture
//   Directed bench for ultrasonic_echo_capture with CHANNELS=2, WIDTH=8,
//   SYNC_STAGES=2, TRIG_CYCLES=4, RISE_TIMEOUT=20, PERIOD_CYCLES=100.
//   Inputs change just after the falling edge; outputs are sampled there.

module tb_ultrasonic_echo_capture;

    localparam int CH = 2;
    localparam int W  = 8;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic          auto_en = 1'b0;
    logic [CH-1:0] echo    = '0;
    logic [CH-1:0] trig;
    logic [W-1:0]  width;
    logic [0:0]    chan;
    logic          valid;
    logic          timeout;
    logic          busy;

    int tests = 0;
    int fails = 0;

    ultrasonic_echo_capture #(
        .CHANNELS     (2),
        .WIDTH        (8),
        .SYNC_STAGES  (2),
        .TRIG_CYCLES  (4),
        .RISE_TIMEOUT (20),
        .PERIOD_CYCLES(100)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .auto_en(auto_en),
        .echo   (echo),
        .trig   (trig),
        .width  (width),
        .chan   (chan),
        .valid  (valid),
        .timeout(timeout),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Passive monitor state.
    int            cyc = 0;
    int            valid_cnt = 0;
    int            busy_fall_cyc = 0;
    int            multi_trig = 0;
    int            trig0_hi = 0;
    int            trig_starts[$];
    logic [CH-1:0] prev_trig = '0;
    logic          prev_busy = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid === 1'b1) valid_cnt++;
        if (trig != '0 && prev_trig == '0) trig_starts.push_back(cyc);
        if ($countones(trig) > 1) multi_trig++;
        if (trig[0] === 1'b1) trig0_hi++;
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_trig = trig;
        prev_busy = busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        auto_en = 1'b0;
        echo    = '0;
        steps(3);
        rst_n = 1'b1;
        steps(2);
        trig_starts.delete();
        trig0_hi   = 0;
        multi_trig = 0;
    endtask

    task automatic wait_trig(input string tag, input logic want_high);
        int n;
        for (n = 0; n < 300; n++) begin
            if ((trig != '0) == want_high) break;
            step();
        end
        check(tag, 32'(n < 300), 32'd1);
    endtask

    // Returns the number of falling edges until valid is seen (bound+1 if never).
    task automatic wait_valid(input int bound, output int k);
        for (k = 1; k <= bound; k++) begin
            step();
            if (valid === 1'b1) break;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        for (n = 0; n < 400; n++) begin
            if (busy === 1'b0) break;
            step();
        end
        check(tag, 32'(n < 400), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            k;
        int            vc0;
        int            lens[2];
        logic [CH-1:0] exp_t;
        lens[0] = 10;
        lens[1] = 60;

        // Reset state
        rst_n = 1'b0;
        steps(2);
        check("rst_trig", 32'(trig), 0);
        check("rst_width", 32'(width), 0);
        check("rst_chan", 32'(chan), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        steps(2);

        // 1: single start, 37-cycle echo on channel 0
        do_reset();
        vc0 = valid_cnt;
        pulse_start();
        wait_trig("s1_trig_hi", 1'b1);
        check("s1_trig_bit", 32'(trig), 32'd1);
        wait_trig("s1_trig_lo", 1'b0);
        steps(5);
        echo[0] = 1'b1;
        steps(37);
        echo[0] = 1'b0;
        wait_valid(10, k);
        check("s1_latency", 32'(k), 3);
        check("s1_width", 32'(width), 37);
        check("s1_chan", 32'(chan), 0);
        check("s1_timeout", 32'(timeout), 0);
        wait_idle("s1_idle");
        check("s1_trig_len", 32'(trig0_hi), 4);
        check("s1_ntrig", 32'(trig_starts.size()), 1);
        check("s1_busy_period", 32'((trig_starts.size() > 0) ? busy_fall_cyc - trig_starts[0] : -1), 100);
        check("s1_nvalid", 32'(valid_cnt - vc0), 1);

        // 2: auto round-robin, widths 10 / 60
        do_reset();
        auto_en = 1'b1;
        for (int m = 0; m < 4; m++) begin
            int c;
            c = m % 2;
            exp_t = '0;
            exp_t[c] = 1'b1;
            wait_trig("s2_trig_hi", 1'b1);
            check("s2_trig_bit", 32'(trig), 32'(exp_t));
            wait_trig("s2_trig_lo", 1'b0);
            steps(5);
            echo[c] = 1'b1;
            steps(lens[c]);
            echo[c] = 1'b0;
            wait_valid(10, k);
            check("s2_latency", 32'(k), 3);
            check("s2_chan", 32'(chan), 32'(c));
            check("s2_width", 32'(width), 32'(lens[c]));
            check("s2_timeout", 32'(timeout), 0);
        end
        auto_en = 1'b0;
        wait_idle("s2_idle");
        check("s2_ntrig", 32'(trig_starts.size()), 4);
        for (int i = 1; i < 4; i++) begin
            check("s2_spacing", 32'((trig_starts.size() > i) ? trig_starts[i] - trig_starts[i-1] : -1), 100);
        end
        check("s2_onehot", 32'(multi_trig), 0);

        // 3a: echo never rises
        do_reset();
        pulse_start();
        wait_trig("s3_trig_hi", 1'b1);
        wait_trig("s3_trig_lo", 1'b0);
        wait_valid(40, k);
        check("s3_rise_to_lat", 32'(k), 20);
        check("s3_width", 32'(width), 0);
        check("s3_timeout", 32'(timeout), 1);
        check("s3_chan", 32'(chan), 0);
        wait_idle("s3_idle");

        // 3b: echo stuck high before the trigger
        do_reset();
        echo[0] = 1'b1;
        steps(5);
        pulse_start();
        wait_trig("s3b_trig_hi", 1'b1);
        wait_trig("s3b_trig_lo", 1'b0);
        wait_valid(40, k);
        check("s3b_rise_to_lat", 32'(k), 20);
        check("s3b_width", 32'(width), 0);
        check("s3b_timeout", 32'(timeout), 1);
        echo[0] = 1'b0;
        wait_idle("s3b_idle");

        // 4: 300-cycle echo saturates the 8-bit count
        do_reset();
        vc0 = valid_cnt;
        pulse_start();
        wait_trig("s4_trig_hi", 1'b1);
        wait_trig("s4_trig_lo", 1'b0);
        steps(2);
        echo[0] = 1'b1;
        wait_valid(300, k);
        check("s4_sat_lat", 32'(k), 257);
        check("s4_width", 32'(width), 255);
        check("s4_timeout", 32'(timeout), 1);
        check("s4_chan", 32'(chan), 0);
        if (k < 300) steps(300 - k);
        echo[0] = 1'b0;
        wait_idle("s4_idle");
        check("s4_nvalid", 32'(valid_cnt - vc0), 1);

        // 5: reset mid-trigger (channel 1 pending) and mid-measure
        vc0 = valid_cnt;
        pulse_start();
        wait_trig("s5_trig_hi", 1'b1);
        check("s5_trig_ch1", 32'(trig), 2);
        step();
        rst_n = 1'b0;
        #1;
        check("s5_rst_trig", 32'(trig), 0);
        check("s5_rst_width", 32'(width), 0);
        check("s5_rst_timeout", 32'(timeout), 0);
        check("s5_rst_busy", 32'(busy), 0);
        steps(2);
        rst_n = 1'b1;
        steps(2);
        pulse_start();
        wait_trig("s5b_trig_hi", 1'b1);
        check("s5b_trig_ch0", 32'(trig), 1);
        wait_trig("s5b_trig_lo", 1'b0);
        steps(3);
        echo[0] = 1'b1;
        steps(10);
        rst_n = 1'b0;
        #1;
        check("s5b_rst_busy", 32'(busy), 0);
        check("s5b_rst_valid", 32'(valid), 0);
        check("s5b_rst_chan", 32'(chan), 0);
        echo[0] = 1'b0;
        steps(2);
        rst_n = 1'b1;
        steps(2);
        check("s5_no_valid", 32'(valid_cnt - vc0), 0);
        pulse_start();
        wait_trig("s5c_trig_hi", 1'b1);
        wait_trig("s5c_trig_lo", 1'b0);
        steps(3);
        echo[0] = 1'b1;
        steps(15);
        echo[0] = 1'b0;
        wait_valid(10, k);
        check("s5c_latency", 32'(k), 3);
        check("s5c_width", 32'(width), 15);
        check("s5c_chan", 32'(chan), 0);
        wait_idle("s5c_idle");

        // 6: extra starts while busy, glitches on the idle channel
        do_reset();
        vc0 = valid_cnt;
        pulse_start();
        step();
        pulse_start();
        wait_trig("s6_trig_lo", 1'b0);
        steps(3);
        echo[0] = 1'b1;
        for (int i = 0; i < 25; i++) begin
            echo[1] = (i % 3 == 1);
            start   = (i == 10);
            step();
        end
        start   = 1'b0;
        echo[0] = 1'b0;
        echo[1] = 1'b0;
        wait_valid(10, k);
        check("s6_width", 32'(width), 25);
        check("s6_chan", 32'(chan), 0);
        check("s6_timeout", 32'(timeout), 0);
        steps(5);
        pulse_start();
        steps(5);
        pulse_start();
        wait_idle("s6_idle");
        steps(5);
        check("s6_stays_idle", 32'(busy), 0);
        check("s6_nvalid", 32'(valid_cnt - vc0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ultrasonic_echo_capture.md
Name: ultrasonic_echo_capture

Overview:
Multi-channel ultrasonic ranging front end. It generates the trigger pulse for each sensor in turn and measures the returned echo pulse width in clk cycles through a synchronised input. It publishes one result per channel with a channel tag, a valid strobe and a timeout flag. It sits between the sensor pins and the distance-conversion / display logic, and is the parametrised successor of the single-channel pulse-width counter.

Parameters:
CHANNELS, 2, number of sensors, >=1; channel index width CW = max(1, clog2(CHANNELS))
WIDTH, 16, width of the echo counter and result
SYNC_STAGES, 2, flops in each echo synchroniser, >=2
TRIG_CYCLES, 120, trigger high time in clk cycles (10 us at 12 MHz)
RISE_TIMEOUT, 6000, maximum cycles to wait for echo rise after trigger
PERIOD_CYCLES, 720000, minimum cycles between successive trigger starts (60 ms at 12 MHz); 32-bit counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-shot request; sampled only in IDLE
auto_en  in  1  free-running mode; continuous channel round-robin while high
echo  in  CHANNELS  raw echo inputs, asynchronous
trig  out  CHANNELS  trigger outputs, at most one bit high at a time
width  out  WIDTH  last measured pulse width; held until next result
chan  out  CW  channel index of the last result
valid  out  1  one-cycle strobe: width/chan/timeout updated
timeout  out  1  qualifies the current result: no echo or saturated count
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): trig=0, width=0, chan=0, valid=0, timeout=0, busy=0; FSM to IDLE; channel pointer ptr=0; all counters and synchronisers 0. Trig drops immediately on reset assertion, including mid-pulse.
- Each echo bit passes through SYNC_STAGES flops. All echo decisions use the synchronised value es and its one-cycle delayed copy.
- IDLE: if start or auto_en, go to TRIG for channel ptr and clear the period counter. start has priority only in the sense that both mean "go".
- TRIG: trig[ptr]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE. Period counter runs from TRIG entry.
- WAIT_RISE: wait for a rising edge of es[ptr] (es=1, delayed=0).
  - Echo already high on entry produces no edge; a stuck-high echo therefore times out.
  - On a rising edge: cnt=1, go to MEASURE.
  - After RISE_TIMEOUT cycles with no edge: publish width=0, timeout=1, go to HOLDOFF.
- MEASURE: cnt+1 each cycle es[ptr]=1.
  - First cycle with es[ptr]=0: publish width=cnt, timeout=0.
  - width therefore equals the number of cycles es was high, and valid appears SYNC_STAGES+1 cycles after the raw falling edge.
  - If cnt reaches 2^WIDTH-1 while es is still high: publish width=all-ones, timeout=1, go to HOLDOFF without waiting for the fall.
- Publish (one cycle): valid=1, chan=ptr; width and timeout update in the same cycle. In every other cycle valid=0.
- HOLDOFF: stay until the period counter reaches PERIOD_CYCLES-1; leave immediately if it already has. On exit, ptr wraps (CHANNELS-1 -> 0), then:
  - auto_en=1: go to TRIG for the new ptr.
  - otherwise: go to IDLE, so one start yields one measurement of one channel.
- start while busy: ignored, no queueing. auto_en falling mid-cycle: current measurement completes and publishes, then IDLE.
- Echo activity on non-selected channels is ignored.
- CHANNELS=1: ptr and chan stay 0.

Test Plan:
Params for all scenarios: CHANNELS=2, WIDTH=8, SYNC_STAGES=2, TRIG_CYCLES=4, RISE_TIMEOUT=20, PERIOD_CYCLES=100.
- start pulse, echo[0] rises 5 cycles after trig falls and stays high 37 cycles -> trig[0] high exactly 4 cycles; valid once, width=37, chan=0, timeout=0; valid 3 cycles after raw fall; busy low at cycle 100 from TRIG entry.
- auto_en=1, echo[0] 10 high, echo[1] 60 high -> results alternate chan 0/1 with widths 10/60; trigger starts exactly 100 cycles apart; trig never has 2 bits set.
- start, echo[0] never rises -> valid 20 cycles after WAIT_RISE entry with width=0, timeout=1. Then echo[0] held high before trig -> same timeout result.
- start, echo[0] high 300 cycles -> valid with width=255, timeout=1 when the count saturates, before echo falls.
- Reset asserted during TRIG and again during MEASURE -> trig low the same cycle, all outputs 0, no valid. After release, start measures correctly with chan=0.
- Extra start pulses while busy, plus glitches on echo[1] during a channel-0 measurement -> exactly one result, width unaffected.
